// File: rtl/data_sram_pkg.sv
// data_sram_pkg: shared constants and types for the data-side SRAM responder.
//   TIMER_OFF / LED_OFF / SCRATCH_OFF : MMIO register byte offsets
//   MMIO_BASE_DEFAULT                 : default base of the MMIO bank
//   region_e                          : request decode result
//   be_merge()                        : byte-enable merge of new data over old
package data_sram_pkg;

  localparam logic [15:0] TIMER_OFF   = 16'h0000;
  localparam logic [15:0] LED_OFF     = 16'h0004;
  localparam logic [15:0] SCRATCH_OFF = 16'h0008;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_mmio.sv
// data_sram_mmio: MMIO register bank (free-running timer, LED, scratch) and
// its combinational read mux. Read data reflects register state before the
// current edge, so the top level can register it alongside RAM read data.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   sel        : MMIO request this cycle
//   we         : byte write enables (0 = read)
//   off_w      : word offset, addr[15:2]
//   wdata      : store data
//   rdata      : read mux output (combinational)
//   led        : LED register
module data_sram_mmio
  import data_sram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  we,
  input  logic [13:0] off_w,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led
);

  logic [31:0] timer;
  logic [31:0] scratch;
  logic [15:0] led_q;
  logic        wr;

  assign wr = sel && (we != 4'b0000);

  // Timer: a write on this edge wins over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (wr && off_w == TIMER_OFF[15:2]) begin
      timer <= be_merge(timer, wdata, we);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      scratch <= '0;
    end else if (wr) begin
      if (off_w == LED_OFF[15:2]) begin
        // Only the low two byte lanes exist in the LED register.
        if (we[0]) led_q[7:0]  <= wdata[7:0];
        if (we[1]) led_q[15:8] <= wdata[15:8];
      end
      if (off_w == SCRATCH_OFF[15:2]) begin
        scratch <= be_merge(scratch, wdata, we);
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (off_w == TIMER_OFF[15:2])        rdata = timer;
    else if (off_w == LED_OFF[15:2])     rdata = {16'b0, led_q};
    else if (off_w == SCRATCH_OFF[15:2]) rdata = scratch;
  end

  assign led = led_q;

endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave: data-side SRAM responder. Decodes each request into RAM,
// MMIO or unmapped space and answers with a fixed one-cycle read latency.
// Build option: define DATA_SRAM_MMIO_EN to include the MMIO bank; without
// it MMIO addresses decode as unmapped and led is tied to 0.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   data_sram_en    : request valid
//   data_sram_we    : byte write enables (0 = read)
//   data_sram_addr  : byte address, bits [1:0] ignored
//   data_sram_wdata : store data
//   data_sram_rdata : response word, one cycle after the request
//   data_sram_err   : unmapped-access pulse aligned with rdata
//   led             : LED register
module data_sram_slave
  import data_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err,
  output logic [15:0] led
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic [31:0]    mem [DEPTH];
  logic [IDX_W-1:0] idx_p0;
  logic           ram_hit_p0;
  logic           mmio_hit_p0;
  region_e        region_p0;
  logic [31:0]    mmio_rdata_p0;
  logic [31:0]    rdata_p1;
  logic           err_p1;
  logic           unused_addr_lsb;

  // ---- p0: request decode ----
  assign idx_p0      = data_sram_addr[ADDR_WIDTH-1:2];
  assign ram_hit_p0  = (data_sram_addr[31:ADDR_WIDTH] == '0);
  assign mmio_hit_p0 = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  always_comb begin
    region_p0 = REG_UNMAPPED;
    if (ram_hit_p0) begin
      region_p0 = REG_RAM;
    end else if (mmio_hit_p0) begin
`ifdef DATA_SRAM_MMIO_EN
      region_p0 = REG_MMIO;
`else
      region_p0 = REG_UNMAPPED;
`endif
    end
  end

`ifdef DATA_SRAM_MMIO_EN
  data_sram_mmio u_mmio (
    .clk   (clk),
    .reset (reset),
    .sel   (data_sram_en && region_p0 == REG_MMIO),
    .we    (data_sram_we),
    .off_w (data_sram_addr[15:2]),
    .wdata (data_sram_wdata),
    .rdata (mmio_rdata_p0),
    .led   (led)
  );
`else
  assign mmio_rdata_p0 = '0;
  assign led           = '0;
`endif

  // RAM contents are never reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_en && region_p0 == REG_RAM) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[idx_p0][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // ---- p1: response register (read-first: captures the pre-write word) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (data_sram_en) begin
      case (region_p0)
        REG_RAM:  rdata_p1 <= mem[idx_p0];
        REG_MMIO: rdata_p1 <= mmio_rdata_p0;
        default:  rdata_p1 <= '0;
      endcase
      err_p1 <= (region_p0 == REG_UNMAPPED);
    end else begin
      err_p1 <= 1'b0;
    end
  end

  assign data_sram_rdata = rdata_p1;
  assign data_sram_err   = err_p1;

endmodule
